// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer for jpeg_core: streams a commanded number of source words, counts output pixels and reports.
// Optional watchdog enabled by defining JPEG_FRAME_CTRL_TIMEOUT_EN.

module jpeg_frame_ctrl #(
  parameter int WORDS_W   = 24,
  parameter int TIMEOUT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_v_i,
  input  logic [WORDS_W-1:0] cmd_words_i,
  output logic               cmd_ready_o,
  input  logic               src_v_i,
  input  logic [31:0]        src_data_i,
  output logic               src_yumi_o,
  output logic               core_valid_o,
  output logic [31:0]        core_data_o,
  output logic [3:0]         core_strb_o,
  output logic               core_last_o,
  input  logic               core_accept_i,
  input  logic               core_idle_i,
  input  logic               core_pix_v_i,
  input  logic               core_pix_accept_i,
  output logic               done_v_o,
  output logic [31:0]        done_pixels_o,
  output logic               done_err_o,
  input  logic               done_yumi_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, REPORT} state_t;

  state_t             state;
  logic [WORDS_W-1:0] remaining;
  logic [31:0]        pix_cnt;
  logic               err;
  logic [1:0]         drain_cnt;
  logic               cmd_ready_q;
  logic               busy_q;
  logic               done_v_q;

  logic in_stream;
  logic in_flight;
  logic last_word;
  logic src_hs;
  logic pix_hs;
  logic timeout_hit;

  assign in_stream = (state == STREAM);
  assign in_flight = (state == STREAM) || (state == DRAIN);
  assign last_word = (remaining == WORDS_W'(1));
  assign src_hs    = in_stream & src_v_i & core_accept_i;
  assign pix_hs    = in_flight & core_pix_v_i & core_pix_accept_i;

  // The word path is a zero-latency pass-through, gated so nothing leaks outside STREAM.
  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign src_yumi_o    = src_hs;
  assign core_valid_o  = in_stream & src_v_i;
  assign core_data_o   = in_stream ? src_data_i : 32'h0;
  assign core_strb_o   = in_stream ? 4'hF : 4'h0;
  assign core_last_o   = in_stream & last_word;
  assign done_v_o      = done_v_q;
  assign done_pixels_o = done_v_q ? pix_cnt : 32'h0;
  assign done_err_o    = done_v_q & err;

`ifdef JPEG_FRAME_CTRL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] wd;

  // Held at zero outside a frame, so every entry to STREAM starts from a clean count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd <= '0;
    end else if (!in_flight || src_hs || pix_hs) begin
      wd <= '0;
    end else if (wd != {TIMEOUT_W{1'b1}}) begin
      wd <= wd + TIMEOUT_W'(1);
    end
  end

  assign timeout_hit = in_flight & ~src_hs & ~pix_hs & (wd == WD_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      remaining   <= '0;
      pix_cnt     <= '0;
      err         <= 1'b0;
      drain_cnt   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_v_q    <= 1'b0;
    end else begin
      if (pix_hs && (pix_cnt != 32'hFFFF_FFFF)) begin
        pix_cnt <= pix_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_v_i) begin
            remaining   <= cmd_words_i;
            pix_cnt     <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_words_i == '0) begin
              err      <= 1'b1;
              done_v_q <= 1'b1;
              state    <= REPORT;
            end else begin
              err   <= 1'b0;
              state <= STREAM;
            end
          end
        end

        STREAM: begin
          if (src_hs) begin
            remaining <= remaining - WORDS_W'(1);
            if (last_word) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end else if (timeout_hit) begin
            err      <= 1'b1;
            done_v_q <= 1'b1;
            state    <= REPORT;
          end
        end

        // The first two DRAIN cycles ignore core_idle_i while the core picks up the last word.
        DRAIN: begin
          if (drain_cnt != 2'd2) begin
            drain_cnt <= drain_cnt + 2'd1;
          end
          if (timeout_hit) begin
            err <= 1'b1;
          end
          if (((drain_cnt == 2'd2) && core_idle_i) || timeout_hit) begin
            done_v_q <= 1'b1;
            state    <= REPORT;
          end
        end

        REPORT: begin
          if (done_yumi_i) begin
            done_v_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Bench for jpeg_frame_ctrl (default build): frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized traffic.

module tb_jpeg_frame_ctrl;

  localparam int WORDS_W = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_v;
  logic [WORDS_W-1:0] cmd_words;
  logic               cmd_ready;
  logic               src_v;
  logic [31:0]        src_data;
  logic               src_yumi;
  logic               core_valid;
  logic [31:0]        core_data;
  logic [3:0]         core_strb;
  logic               core_last;
  logic               core_accept;
  logic               core_idle;
  logic               pix_v;
  logic               pix_accept;
  logic               done_v;
  logic [31:0]        done_pixels;
  logic               done_err;
  logic               done_yumi;
  logic               busy;

  always #5 clk = ~clk;

  jpeg_frame_ctrl #(.WORDS_W(WORDS_W), .TIMEOUT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_v_i(cmd_v), .cmd_words_i(cmd_words), .cmd_ready_o(cmd_ready),
    .src_v_i(src_v), .src_data_i(src_data), .src_yumi_o(src_yumi),
    .core_valid_o(core_valid), .core_data_o(core_data), .core_strb_o(core_strb),
    .core_last_o(core_last), .core_accept_i(core_accept), .core_idle_i(core_idle),
    .core_pix_v_i(pix_v), .core_pix_accept_i(pix_accept),
    .done_v_o(done_v), .done_pixels_o(done_pixels), .done_err_o(done_err),
    .done_yumi_i(done_yumi), .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_REPORT = 3;

  int                 m_phase;
  logic [WORDS_W-1:0] m_left;
  logic [31:0]        m_pix;
  logic               m_err;
  int                 m_drain_cycles;

  int          xfer_cnt;
  int          last_pos;
  logic [31:0] consumed[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, words left and pixel tally, advanced from the inputs at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase        <= P_IDLE;
      m_left         <= '0;
      m_pix          <= '0;
      m_err          <= 1'b0;
      m_drain_cycles <= 0;
    end else begin
      if ((m_phase == P_STREAM || m_phase == P_DRAIN) && pix_v && pix_accept && m_pix != 32'hFFFF_FFFF)
        m_pix <= m_pix + 1;
      case (m_phase)
        P_IDLE: if (cmd_v) begin
          m_pix   <= 0;
          m_left  <= cmd_words;
          m_err   <= (cmd_words == 0);
          m_phase <= (cmd_words == 0) ? P_REPORT : P_STREAM;
        end
        P_STREAM: if (src_v && core_accept) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase        <= P_DRAIN;
            m_drain_cycles <= 0;
          end
        end
        P_DRAIN: begin
          if (m_drain_cycles >= 2 && core_idle) m_phase <= P_REPORT;
          m_drain_cycles <= m_drain_cycles + 1;
        end
        default: if (done_yumi) m_phase <= P_IDLE;
      endcase
    end
  end

  // Compare every output against the model half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check_output("rst_cmd_ready", cmd_ready, 1);
      check_output("rst_busy", busy, 0);
      check_output("rst_core_valid", core_valid, 0);
      check_output("rst_src_yumi", src_yumi, 0);
      check_output("rst_core_strb", core_strb, 0);
      check_output("rst_core_last", core_last, 0);
      check_output("rst_done_v", done_v, 0);
      check_output("rst_done_pixels", done_pixels, 0);
      check_output("rst_done_err", done_err, 0);
    end else begin
      check_output("cmd_ready", cmd_ready, m_phase == P_IDLE);
      check_output("busy", busy, m_phase != P_IDLE);
      check_output("core_valid", core_valid, (m_phase == P_STREAM) && src_v);
      check_output("src_yumi", src_yumi, (m_phase == P_STREAM) && src_v && core_accept);
      check_output("core_last", core_last, (m_phase == P_STREAM) && (m_left == 1));
      check_output("core_strb", core_strb, (m_phase == P_STREAM) ? 4'hF : 4'h0);
      check_output("done_v", done_v, m_phase == P_REPORT);
      if (m_phase == P_STREAM && src_v)
        check_output("core_data", core_data, src_data);
      if (m_phase == P_REPORT) begin
        check_output("done_pixels", done_pixels, m_pix);
        check_output("done_err", done_err, m_err);
      end
      if (src_yumi) begin
        xfer_cnt++;
        consumed.push_back(core_data);
        if (core_last) last_pos = xfer_cnt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic c_v, input int words, input logic s_v, input logic acc,
                                input logic idle, input logic p_v, input logic p_acc, input logic d_y);
    cmd_v       = c_v;
    cmd_words   = WORDS_W'(words);
    src_v       = s_v;
    src_data    = $urandom;
    core_accept = acc;
    core_idle   = idle;
    pix_v       = p_v;
    pix_accept  = p_acc;
    done_yumi   = d_y;
  endtask

  task automatic wait_report(input string name);
    int n = 0;
    while (!done_v && n < 40) begin
      tick();
      n++;
    end
    check_output(name, done_v, 1);
  endtask

  task automatic finish_report();
    done_yumi = 1'b1;
    tick();
    done_yumi = 1'b0;
  endtask

  task automatic run_three_words();
    xfer_cnt = 0;
    last_pos = 0;
    apply_stimulus(1, 3, 1, 1, 1, 1, 1, 0);
    tick();
    cmd_v = 1'b0;
    tick();
    tick();
    pix_v = 1'b0;
    wait_report("three_reached_report");
    check_output("three_xfers", xfer_cnt, 3);
    check_output("three_last_pos", last_pos, 3);
    check_output("three_pixels", done_pixels, 32'd2);
    check_output("three_err", done_err, 0);
    check_output("three_model_pix", m_pix, 32'd2);
    finish_report();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int next_idx;
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_three_words();

    // Zero-length command goes straight to an error report.
    apply_stimulus(1, 0, 1, 1, 1, 0, 0, 0);
    tick();
    cmd_v = 1'b0;
    check_output("zero_done_v", done_v, 1);
    check_output("zero_err", done_err, 1);
    check_output("zero_pixels", done_pixels, 0);
    check_output("zero_core_valid", core_valid, 0);
    check_output("zero_model_err", m_err, 1);
    finish_report();

    // Four words with a toggling accept and gaps on the source; words tagged by position.
    xfer_cnt = 0;
    last_pos = 0;
    consumed.delete();
    apply_stimulus(1, 4, 0, 0, 1, 0, 0, 0);
    tick();
    cmd_v = 1'b0;
    for (int c = 0; c < 80 && consumed.size() < 4; c++) begin
      next_idx    = consumed.size();
      core_accept = (c % 2 == 0);
      src_v       = ($urandom_range(0, 2) != 0);
      src_data    = 32'hA000_0000 + next_idx;
      tick();
    end
    src_v = 1'b0;
    wait_report("four_reached_report");
    check_output("four_xfers", xfer_cnt, 4);
    check_output("four_last_pos", last_pos, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < consumed.size())
        check_output("four_order", consumed[i], 32'hA000_0000 + i);
    end
    finish_report();

    // Starved source: without the watchdog the frame stays in STREAM.
    apply_stimulus(1, 2, 0, 1, 1, 0, 0, 0);
    tick();
    cmd_v = 1'b0;
    repeat (20) tick();
    check_output("starve_ready", cmd_ready, 0);
    check_output("starve_done_v", done_v, 0);
    check_output("starve_busy", busy, 1);

    // Reset in mid-STREAM takes effect before the next edge.
    src_v       = 1'b1;
    core_accept = 1'b0;
    #1;
    check_output("pre_reset_valid", core_valid, 1);
    rst = 1'b1;
    #1;
    check_output("reset_valid", core_valid, 0);
    check_output("reset_ready", cmd_ready, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_strb", core_strb, 0);
    #5;
    rst   = 1'b0;
    src_v = 1'b0;
    tick();
    run_three_words();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
